// File: rtl/avr_xmem_pkg.sv
// Shared register map, bit positions and defaults for the AVR external-SRAM
// byte FIFO bridge.
package avr_xmem_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int DATA_W    = 8;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_TXLVL  = 3'd2;
  localparam logic [2:0] REG_RXLVL  = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_UNF   = 5;

  localparam int CTRL_RX_IE    = 0;
  localparam int CTRL_CLR_ERR  = 5;
  localparam int CTRL_TX_FLUSH = 6;
  localparam int CTRL_RX_FLUSH = 7;

  typedef enum logic {
    IDLE   = 1'b0,
    RD_ACK = 1'b1
  } rd_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with flush and occupancy output; push and pop may
// coincide even when full.
module sync_fifo
  import avr_xmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  count;
  logic              push_ok, pop_ok;

  assign full    = (count == LVL_FULL);
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty & ~flush;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok) & ~flush;
  assign dout    = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + LVL_ONE;
        2'b01:   count <= count - LVL_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/avr_xmem_fifo.sv
// AVR external-SRAM window exposing a TX and an RX byte FIFO through an
// eight-register map; reads insert one wait state, writes insert none.
module avr_xmem_fifo
  import avr_xmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  bus_a,
  input  logic [7:0]  bus_d_wr,
  output logic [7:0]  bus_d_rd,
  input  logic        bus_cs,
  input  logic        bus_oe,
  input  logic        bus_we,
  output logic        bus_wait,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  // Levels reach DEPTH, which needs nine bits at DEPTH=256; clamp to a byte.
  function automatic logic [7:0] lvl_byte(input logic [LVL_W-1:0] l);
    logic [8:0] w;
    w = 9'(l);
    if (w > 9'd255) return 8'hFF;
    return w[7:0];
  endfunction

  rd_state_t  state, state_nxt;
  logic [2:0] reg_sel;
  logic       unused_a;
  logic [7:0] rd_q, rd_val, status;
  logic       tx_ovf, rx_unf, rx_ie;
  logic       wr_en, rd_start, ctrl_wr;
  logic       tx_push_req, tx_push, tx_pop, tx_drop, tx_flush;
  logic       rx_push, rx_pop, rx_unf_set, rx_flush;
  logic [7:0] tx_dout, rx_dout;
  logic [LVL_W-1:0] tx_lvl, rx_lvl;
  logic       tx_full, tx_empty, rx_full, rx_empty;

  assign reg_sel  = bus_a[2:0];
  assign unused_a = ^bus_a[9:3];

  assign wr_en    = bus_cs & bus_we;
  assign rd_start = (state == IDLE) & bus_cs & bus_oe;
  assign ctrl_wr  = wr_en & (reg_sel == REG_CTRL);
  assign tx_flush = ctrl_wr & bus_d_wr[CTRL_TX_FLUSH];
  assign rx_flush = ctrl_wr & bus_d_wr[CTRL_RX_FLUSH];

  assign tx_valid    = ~tx_empty;
  assign tx_data     = tx_dout;
  assign tx_pop      = tx_valid & tx_ready;
  assign tx_push_req = wr_en & (reg_sel == REG_DATA);
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign tx_drop     = tx_push_req & ~tx_push;

  assign rx_ready   = ~rx_full;
  assign rx_push    = rx_valid & rx_ready;
  assign rx_pop     = rd_start & (reg_sel == REG_DATA) & ~rx_empty;
  assign rx_unf_set = rd_start & (reg_sel == REG_DATA) & rx_empty;

  sync_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) u_tx_fifo (
    .clk(clk), .rst(rst), .flush(tx_flush), .push(tx_push), .din(bus_d_wr),
    .pop(tx_pop), .dout(tx_dout), .level(tx_lvl), .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) u_rx_fifo (
    .clk(clk), .rst(rst), .flush(rx_flush), .push(rx_push), .din(rx_data),
    .pop(rx_pop), .dout(rx_dout), .level(rx_lvl), .full(rx_full), .empty(rx_empty)
  );

  always_comb begin
    status              = '0;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_TX_OVF]   = tx_ovf;
    status[ST_RX_UNF]   = rx_unf;
  end

  always_comb begin
    rd_val = 8'h00;
    case (reg_sel)
      REG_DATA:   rd_val = rx_empty ? 8'h00 : rx_dout;
      REG_STATUS: rd_val = status;
      REG_TXLVL:  rd_val = lvl_byte(tx_lvl);
      REG_RXLVL:  rd_val = lvl_byte(rx_lvl);
      REG_CTRL:   rd_val = {7'b0, rx_ie};
      default:    rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus_wait  = 1'b0;
    bus_d_rd  = 8'h00;
    case (state)
      IDLE: begin
        bus_wait = rd_start;
        if (rd_start) state_nxt = RD_ACK;
      end
      RD_ACK: begin
        bus_d_rd  = rd_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q   <= 8'h00;
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
      rx_ie  <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (rd_start) rd_q <= rd_val;
      if (ctrl_wr)  rx_ie <= bus_d_wr[CTRL_RX_IE];
      if (ctrl_wr && bus_d_wr[CTRL_CLR_ERR]) begin
        tx_ovf <= 1'b0;
        rx_unf <= 1'b0;
      end else begin
        if (tx_drop)    tx_ovf <= 1'b1;
        if (rx_unf_set) rx_unf <= 1'b1;
      end
      irq <= rx_ie & ~rx_empty;
    end
  end

endmodule

// File: tb/tb_avr_xmem_fifo.sv
// Directed bench for avr_xmem_fifo: register map, wait states, FIFO order,
// overflow/underflow, flush, irq timing and reset during a read.
module tb_avr_xmem_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] bus_a;
  logic [7:0] bus_d_wr;
  logic [7:0] bus_d_rd;
  logic       bus_cs, bus_oe, bus_we;
  logic       bus_wait;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       irq;

  int checks = 0;
  int errors = 0;
  logic [7:0] rd;
  logic [7:0] exp_q [$];
  logic [7:0] exp_b;

  always #5 clk = ~clk;

  avr_xmem_fifo #(.DEPTH(16), .LVL_W(5)) dut (
    .clk(clk), .rst(rst), .bus_a(bus_a), .bus_d_wr(bus_d_wr), .bus_d_rd(bus_d_rd),
    .bus_cs(bus_cs), .bus_oe(bus_oe), .bus_we(bus_we), .bus_wait(bus_wait),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic bus_write(input logic [9:0] a, input logic [7:0] d);
    bus_a = a; bus_d_wr = d; bus_cs = 1'b1; bus_we = 1'b1;
    @(posedge clk); #1;
    bus_cs = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [9:0] a, input bit drop_rx, output logic [7:0] d);
    bus_a = a; bus_cs = 1'b1; bus_oe = 1'b1;
    #1;
    chk("wait_in_idle", bus_wait, 1);
    @(posedge clk); #1;
    if (drop_rx) rx_valid = 1'b0;
    chk("wait_in_ack", bus_wait, 0);
    d = bus_d_rd;
    bus_cs = 1'b0; bus_oe = 1'b0;
    @(posedge clk); #1;
    chk("d_rd_idle", bus_d_rd, 8'h00);
  endtask

  task automatic rx_byte(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bus_a = '0; bus_d_wr = '0; bus_cs = 0; bus_oe = 0; bus_we = 0;
    tx_ready = 0; rx_data = '0; rx_valid = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_bus_wait", bus_wait, 0);
    chk("rst_d_rd", bus_d_rd, 8'h00);
    chk("rst_irq", irq, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_rx_ready", rx_ready, 1);
    bus_read(10'h001, 0, rd); chk("rst_status", rd, 8'h0A);
    bus_read(10'h002, 0, rd); chk("rst_txlvl", rd, 8'h00);
    bus_read(10'h003, 0, rd); chk("rst_rxlvl", rd, 8'h00);

    // TX order with a held-off consumer
    bus_write(10'h000, 8'h11);
    bus_write(10'h000, 8'h22);
    bus_write(10'h000, 8'h33);
    bus_read(10'h002, 0, rd); chk("txlvl_3", rd, 8'h03);
    tx_ready = 1'b1;
    #1 chk("tx_d0", tx_data, 8'h11);
    @(posedge clk); #1; chk("tx_d1", tx_data, 8'h22);
    @(posedge clk); #1; chk("tx_d2", tx_data, 8'h33);
    @(posedge clk); #1; chk("tx_drained", tx_valid, 0);
    tx_ready = 1'b0;

    // TX overflow: 17th byte dropped
    for (int i = 0; i < 17; i++) bus_write(10'h000, 8'h40 + 8'(i));
    bus_read(10'h002, 0, rd); chk("txlvl_16", rd, 8'h10);
    bus_read(10'h001, 0, rd); chk("status_ovf", rd, 8'h19);
    bus_write(10'h004, 8'h20);
    bus_read(10'h001, 0, rd); chk("status_ovf_clr", rd, 8'h09);
    tx_ready = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      chk("tx_full_order", {tx_valid, tx_data}, {1'b1, 8'h40 + 8'(i)});
      @(posedge clk); #1;
    end
    chk("tx_17th_absent", tx_valid, 0);
    tx_ready = 1'b0;

    // RX with interrupt, then underflow
    bus_write(10'h004, 8'h01);
    bus_read(10'h004, 0, rd); chk("ctrl_ie", rd, 8'h01);
    rx_byte(8'hA5);
    chk("irq_not_yet", irq, 0);
    @(posedge clk); #1; chk("irq_set", irq, 1);
    bus_read(10'h000, 0, rd); chk("rx_a5", rd, 8'hA5);
    chk("irq_clr", irq, 0);
    bus_read(10'h003, 0, rd); chk("rxlvl_0", rd, 8'h00);
    bus_read(10'h000, 0, rd); chk("rx_unf_data", rd, 8'h00);
    bus_read(10'h001, 0, rd); chk("status_unf", rd, 8'h2A);
    bus_write(10'h004, 8'hE1);
    bus_read(10'h004, 0, rd); chk("ctrl_selfclr", rd, 8'h01);
    bus_read(10'h001, 0, rd); chk("status_unf_clr", rd, 8'h0A);
    bus_write(10'h004, 8'h00);

    // RX full with producer held, simultaneous push/pop
    for (int i = 0; i < 16; i++) begin
      rx_byte(8'h60 + 8'(i));
      exp_q.push_back(8'h60 + 8'(i));
    end
    bus_read(10'h003, 0, rd); chk("rxlvl_16", rd, 8'h10);
    bus_read(10'h001, 0, rd); chk("status_rxfull", rd, 8'h06);
    chk("rx_ready_full", rx_ready, 0);
    rx_data = 8'h70; rx_valid = 1'b1;
    bus_read(10'h000, 0, rd);
    rx_valid = 1'b0;
    exp_b = exp_q.pop_front(); chk("rx_full_pop", rd, exp_b);
    exp_q.push_back(8'h70);
    bus_read(10'h003, 0, rd); chk("rxlvl_stays_16", rd, 8'h10);
    bus_read(10'h000, 0, rd);
    exp_b = exp_q.pop_front(); chk("rx_pop2", rd, exp_b);
    rx_data = 8'h71; rx_valid = 1'b1;
    bus_read(10'h000, 1, rd);
    exp_b = exp_q.pop_front(); chk("rx_same_cycle", rd, exp_b);
    exp_q.push_back(8'h71);
    bus_read(10'h003, 0, rd); chk("rxlvl_15", rd, 8'h0F);
    while (exp_q.size() > 0) begin
      bus_read(10'h000, 0, rd);
      exp_b = exp_q.pop_front(); chk("rx_order", rd, exp_b);
    end
    bus_read(10'h001, 0, rd); chk("status_rx_drained", rd, 8'h0A);

    // RX flush beats a same-cycle push
    rx_byte(8'h81); rx_byte(8'h82); rx_byte(8'h83);
    bus_a = 10'h004; bus_d_wr = 8'h80; bus_cs = 1'b1; bus_we = 1'b1;
    rx_data = 8'h99; rx_valid = 1'b1;
    @(posedge clk); #1;
    bus_cs = 1'b0; bus_we = 1'b0; rx_valid = 1'b0;
    bus_read(10'h003, 0, rd); chk("flush_rxlvl", rd, 8'h00);
    bus_read(10'h001, 0, rd); chk("flush_status", rd, 8'h0A);

    // Address aliasing and unused offsets
    bus_write(10'h3F8, 8'h5C);
    bus_read(10'h10A, 0, rd); chk("alias_txlvl", rd, 8'h01);
    chk("alias_tx_data", tx_data, 8'h5C);
    bus_write(10'h006, 8'hFF);
    bus_read(10'h005, 0, rd); chk("reg5_zero", rd, 8'h00);
    bus_read(10'h002, 0, rd); chk("reg6_ignored", rd, 8'h01);

    // Reset during RD_ACK aborts the read
    bus_a = 10'h001; bus_cs = 1'b1; bus_oe = 1'b1;
    @(posedge clk); #1;
    chk("ack_status", bus_d_rd, 8'h08);
    rst = 1'b1; bus_cs = 1'b0; bus_oe = 1'b0;
    #1;
    chk("abort_d_rd", bus_d_rd, 8'h00);
    chk("abort_wait", bus_wait, 0);
    chk("abort_tx_valid", tx_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    bus_read(10'h001, 0, rd); chk("post_rst_status", rd, 8'h0A);
    chk("post_rst_irq", irq, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
